// File: rtl/sound_latch_bridge_if.sv
// 68K/Z80 sound latch bus bundle.
// master drives selects and data; slave is the bridge.
interface sound_latch_bridge_if #(
  parameter int BANK_BITS = 5
);
  logic                 m68k_as_n;
  logic                 m68k_lds_n;
  logic                 m68k_latch_cs;
  logic [7:0]           m68k_dout;
  logic                 m68k_dtack_n;
  logic                 z80_latch_cs;
  logic                 z80_latch_clr_cs;
  logic                 z80_bank_set_cs;
  logic [7:0]           z80_dout;
  logic [7:0]           z80_latch_dout;
  logic                 z80_irq_n;
  logic [BANK_BITS-1:0] z80_bank;
  logic                 overrun;

  modport master (
    output m68k_as_n, m68k_lds_n, m68k_latch_cs, m68k_dout,
    output z80_latch_cs, z80_latch_clr_cs, z80_bank_set_cs,
    output z80_dout,
    input  m68k_dtack_n, z80_latch_dout, z80_irq_n,
    input  z80_bank, overrun
  );

  modport slave (
    input  m68k_as_n, m68k_lds_n, m68k_latch_cs, m68k_dout,
    input  z80_latch_cs, z80_latch_clr_cs, z80_bank_set_cs,
    input  z80_dout,
    output m68k_dtack_n, z80_latch_dout, z80_irq_n,
    output z80_bank, overrun
  );
endinterface

// File: rtl/sound_latch_bridge.sv
// 68K -> Z80 sound command latch with DTACK timing,
// pending IRQ, sticky overrun flag and audio bank register.
module sound_latch_bridge #(
  parameter int DTACK_WAIT = 1,
  parameter int BANK_BITS  = 5
) (
  input  logic                clk,
  input  logic                reset,
  sound_latch_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 wr_q, clr_q, bnk_q, arm_q;
  logic [7:0]           latch_q, latch_d;
  logic                 pend_q, pend_d;
  logic                 ovr_q, ovr_d;
  logic [BANK_BITS-1:0] bank_q, bank_d;
  logic                 wr_lvl, wr_ev, clr_ev, bnk_ev;
  logic                 unused_ok;

  assign wr_lvl = bus.m68k_latch_cs & ~bus.m68k_lds_n;

  // arm_q masks the first cycle after reset so held selects stay quiet
  assign wr_ev  = arm_q & wr_lvl & ~wr_q;
  assign clr_ev = arm_q & bus.z80_latch_clr_cs & ~clr_q;
  assign bnk_ev = arm_q & bus.z80_bank_set_cs & ~bnk_q;

  assign unused_ok = ^{bus.z80_latch_cs, bus.z80_dout};

  always_comb begin
    latch_d = latch_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    bank_d  = bank_q;
    if (wr_ev) begin
      latch_d = bus.m68k_dout;
      pend_d  = 1'b1;
      ovr_d   = ovr_q | pend_q;
    end else if (clr_ev) begin
      pend_d  = 1'b0;
    end
    if (bnk_ev) begin
      bank_d = bus.z80_dout[BANK_BITS-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_ev) begin
          if (DTACK_WAIT == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'd1;
          end
        end
      end
      S_WAIT: begin
        if (bus.m68k_as_n) begin
          state_d = S_IDLE;
        end else if (cnt_q == 3'(DTACK_WAIT)) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_ACK: begin
        if (bus.m68k_as_n) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      clr_q   <= 1'b0;
      bnk_q   <= 1'b0;
      arm_q   <= 1'b0;
      latch_q <= 8'h00;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_lvl;
      clr_q   <= bus.z80_latch_clr_cs;
      bnk_q   <= bus.z80_bank_set_cs;
      arm_q   <= 1'b1;
      latch_q <= latch_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      bank_q  <= bank_d;
    end
  end

  assign bus.m68k_dtack_n   = (state_q != S_ACK);
  assign bus.z80_latch_dout = latch_q;
  assign bus.z80_irq_n      = ~pend_q;
  assign bus.z80_bank       = bank_q;
  assign bus.overrun        = ovr_q;

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Randomized bench for sound_latch_bridge against a
// cycle-level behavioural model of the latch protocol.
module tb_sound_latch_bridge;
  localparam int W  = 2;
  localparam int BB = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sound_latch_bridge_if #(.BANK_BITS(BB)) bus ();

  sound_latch_bridge #(
    .DTACK_WAIT(W),
    .BANK_BITS (BB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // model state
  bit          m_wr_p, m_clr_p, m_bk_p, m_arm;
  bit   [7:0]  m_latch;
  bit          m_pend, m_ovr;
  bit   [BB-1:0] m_bank;
  bit          m_busy;
  int          m_age;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // one clock edge: advance model with pre-edge inputs, compare
  task automatic step();
    bit wl, we, ce, be;
    @(posedge clk);
    if (reset) begin
      m_wr_p = 0; m_clr_p = 0; m_bk_p = 0; m_arm = 0;
      m_latch = 8'h00; m_pend = 0; m_ovr = 0;
      m_bank = '0; m_busy = 0; m_age = 0;
    end else begin
      wl = bus.m68k_latch_cs && !bus.m68k_lds_n;
      we = wl && !m_wr_p && m_arm;
      ce = bus.z80_latch_clr_cs && !m_clr_p && m_arm;
      be = bus.z80_bank_set_cs && !m_bk_p && m_arm;
      m_wr_p  = wl;
      m_clr_p = bus.z80_latch_clr_cs;
      m_bk_p  = bus.z80_bank_set_cs;
      m_arm   = 1;
      if (we) begin
        if (m_pend) m_ovr = 1;
        m_latch = bus.m68k_dout;
        m_pend  = 1;
      end else if (ce) begin
        m_pend = 0;
      end
      if (be) m_bank = bus.z80_dout[BB-1:0];
      if (m_busy) begin
        if (bus.m68k_as_n) m_busy = 0;
        else if (m_age < 100) m_age++;
      end else if (we) begin
        m_busy = 1;
        m_age  = 0;
      end
    end
    #1;
    check("irq_n", bus.z80_irq_n, !m_pend);
    check("latch", bus.z80_latch_dout, m_latch);
    check("dtack_n", bus.m68k_dtack_n,
          !(m_busy && m_age >= W));
    check("bank", bus.z80_bank, m_bank);
    check("overrun", bus.overrun, m_ovr);
  endtask

  task automatic idle_bus();
    bus.m68k_as_n        = 1'b1;
    bus.m68k_lds_n       = 1'b1;
    bus.m68k_latch_cs    = 1'b0;
    bus.z80_latch_cs     = 1'b0;
    bus.z80_latch_clr_cs = 1'b0;
    bus.z80_bank_set_cs  = 1'b0;
  endtask

  task automatic write68k(input logic [7:0] d);
    bus.m68k_as_n     = 1'b0;
    bus.m68k_lds_n    = 1'b0;
    bus.m68k_latch_cs = 1'b1;
    bus.m68k_dout     = d;
    repeat (4) step();
    idle_bus();
    step();
  endtask

  task automatic clear_z80();
    bus.z80_latch_clr_cs = 1'b1;
    step();
    bus.z80_latch_clr_cs = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    idle_bus();
    bus.m68k_dout = 8'h00;
    bus.z80_dout  = 8'h00;
    step();
    step();
    check("rst_dtack", bus.m68k_dtack_n, 1'b1);
    check("rst_irq", bus.z80_irq_n, 1'b1);
    check("rst_latch", bus.z80_latch_dout, 8'h00);
    reset = 1'b0;
    step();

    // write 5A: IRQ after event edge, DTACK W+1 edges later
    bus.m68k_as_n     = 1'b0;
    bus.m68k_lds_n    = 1'b0;
    bus.m68k_latch_cs = 1'b1;
    bus.m68k_dout     = 8'h5A;
    step();
    check("w5a_irq", bus.z80_irq_n, 1'b0);
    check("w5a_latch", bus.z80_latch_dout, 8'h5A);
    check("dtk_e1", bus.m68k_dtack_n, 1'b1);
    step();
    check("dtk_e2", bus.m68k_dtack_n, 1'b1);
    step();
    check("dtk_e3", bus.m68k_dtack_n, 1'b0);
    step();
    check("dtk_hold", bus.m68k_dtack_n, 1'b0);
    idle_bus();
    step();
    check("dtk_rel", bus.m68k_dtack_n, 1'b1);
    check("w5a_single", bus.overrun, 1'b0);

    clear_z80();
    check("clr_irq", bus.z80_irq_n, 1'b1);
    check("clr_keep", bus.z80_latch_dout, 8'h5A);

    write68k(8'h11);
    check("ovr_first", bus.overrun, 1'b0);
    write68k(8'hA5);
    check("ovr_set", bus.overrun, 1'b1);
    check("ovr_latch", bus.z80_latch_dout, 8'hA5);

    // write and clear edges together: write wins
    clear_z80();
    bus.m68k_as_n        = 1'b0;
    bus.m68k_lds_n       = 1'b0;
    bus.m68k_latch_cs    = 1'b1;
    bus.m68k_dout        = 8'h77;
    bus.z80_latch_clr_cs = 1'b1;
    step();
    check("sim_irq", bus.z80_irq_n, 1'b0);
    check("sim_latch", bus.z80_latch_dout, 8'h77);
    step();
    idle_bus();
    step();

    bus.z80_dout        = 8'hF3;
    bus.z80_bank_set_cs = 1'b1;
    step();
    bus.z80_bank_set_cs = 1'b0;
    step();
    check("bank_f3", bus.z80_bank, 5'h13);

    // reset mid-WAIT with the select held across release
    bus.m68k_as_n     = 1'b0;
    bus.m68k_lds_n    = 1'b0;
    bus.m68k_latch_cs = 1'b1;
    bus.m68k_dout     = 8'hC3;
    step();
    step();
    reset = 1'b1;
    step();
    check("rw_dtack", bus.m68k_dtack_n, 1'b1);
    check("rw_irq", bus.z80_irq_n, 1'b1);
    check("rw_latch", bus.z80_latch_dout, 8'h00);
    check("rw_ovr", bus.overrun, 1'b0);
    check("rw_bank", bus.z80_bank, 5'h00);
    reset = 1'b0;
    step();
    check("held_noev", bus.z80_irq_n, 1'b1);
    step();
    check("held_noev2", bus.m68k_dtack_n, 1'b1);
    idle_bus();
    step();

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0)
        bus.m68k_as_n = ~bus.m68k_as_n;
      if ($urandom_range(0, 3) == 0)
        bus.m68k_lds_n = ~bus.m68k_lds_n;
      if ($urandom_range(0, 3) == 0)
        bus.m68k_latch_cs = ~bus.m68k_latch_cs;
      if ($urandom_range(0, 4) == 0)
        bus.z80_latch_clr_cs = ~bus.z80_latch_clr_cs;
      if ($urandom_range(0, 6) == 0)
        bus.z80_bank_set_cs = ~bus.z80_bank_set_cs;
      bus.z80_latch_cs = 1'($urandom_range(0, 1));
      bus.m68k_dout    = 8'($urandom);
      bus.z80_dout     = 8'($urandom);
      reset = ($urandom_range(0, 249) == 0);
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
